// File: rtl/alu_operand_loader.sv
// Operand entry front-end for the 4-bit ALU: debounces enter/clear buttons and
// walks A -> B -> op -> READY, holding registered operands stable while READY.
module alu_operand_loader #(
    parameter int unsigned DATA_W          = 4,
    parameter int unsigned SEL_W           = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sw_data,
    input  logic [SEL_W-1:0]  sw_sel,
    input  logic              btn_enter,
    input  logic              btn_clear,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic [SEL_W-1:0]  op_sel,
    output logic              op_valid,
    output logic              op_start,
    output logic [1:0]        state_o
);

    localparam int unsigned NUM_BTN   = 2;
    localparam int unsigned BTN_ENTER = 0;
    localparam int unsigned BTN_CLEAR = 1;
    localparam int unsigned CNT_W     = ($clog2(DEBOUNCE_CYCLES) > 0) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A  = 2'b00,
        ST_LOAD_B  = 2'b01,
        ST_LOAD_OP = 2'b10,
        ST_READY   = 2'b11
    } state_t;

    // Button conditioning state, one lane per button
    logic [NUM_BTN-1:0]            btn_raw;
    logic [NUM_BTN-1:0]            sync1_q, sync1_d;
    logic [NUM_BTN-1:0]            sync2_q, sync2_d;
    logic [NUM_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NUM_BTN-1:0]            db_q, db_d;
    logic [NUM_BTN-1:0]            db_dly_q, db_dly_d;
    logic [NUM_BTN-1:0]            press;
    logic                          enter_press;
    logic                          clear_press;

    // Entry FSM and operand registers
    state_t              state_q, state_d;
    logic [DATA_W-1:0]   op_a_q, op_a_d;
    logic [DATA_W-1:0]   op_b_q, op_b_d;
    logic [SEL_W-1:0]    op_sel_q, op_sel_d;
    logic                op_valid_q, op_valid_d;
    logic                op_start_q, op_start_d;

    assign btn_raw = {btn_clear, btn_enter};

    // Synchronize, then require DEBOUNCE_CYCLES consecutive mismatching cycles
    // before the debounced level follows; any agreeing cycle restarts the count.
    always_comb begin
        sync1_d  = btn_raw;
        sync2_d  = sync1_q;
        db_d     = db_q;
        db_dly_d = db_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < NUM_BTN; i++) begin
            if (sync2_q[i] == db_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                db_d[i]  = sync2_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign press       = db_q & ~db_dly_q;
    assign enter_press = press[BTN_ENTER];
    assign clear_press = press[BTN_CLEAR];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            cnt_q    <= '0;
            db_q     <= '0;
            db_dly_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            cnt_q    <= cnt_d;
            db_q     <= db_d;
            db_dly_q <= db_dly_d;
        end
    end

    // Next-state and capture logic; clear outranks enter in the same cycle
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_sel_d   = op_sel_q;
        op_start_d = 1'b0;

        if (clear_press) begin
            state_d  = ST_LOAD_A;
            op_a_d   = '0;
            op_b_d   = '0;
            op_sel_d = '0;
        end else if (enter_press) begin
            unique case (state_q)
                ST_LOAD_A: begin
                    op_a_d  = sw_data;
                    state_d = ST_LOAD_B;
                end
                ST_LOAD_B: begin
                    op_b_d  = sw_data;
                    state_d = ST_LOAD_OP;
                end
                ST_LOAD_OP: begin
                    op_sel_d   = sw_sel;
                    state_d    = ST_READY;
                    op_start_d = 1'b1;
                end
                ST_READY: begin
                    op_a_d  = sw_data;
                    state_d = ST_LOAD_B;
                end
                default: state_d = ST_LOAD_A;
            endcase
        end

        op_valid_d = (state_d == ST_READY);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOAD_A;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_sel_q   <= '0;
            op_valid_q <= 1'b0;
            op_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_sel_q   <= op_sel_d;
            op_valid_q <= op_valid_d;
            op_start_q <= op_start_d;
        end
    end

    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign op_sel   = op_sel_q;
    assign op_valid = op_valid_q;
    assign op_start = op_start_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed bench for alu_operand_loader with DEBOUNCE_CYCLES=4: a table of
// clean button presses plus hand-written reset, bounce and glitch sequences.
module tb_alu_operand_loader;

    localparam int unsigned DATA_W = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned DB     = 4;
    localparam int unsigned CAP_EDGE = DB + 3;

    logic              clk;
    logic              rst_n;
    logic [DATA_W-1:0] sw_data;
    logic [SEL_W-1:0]  sw_sel;
    logic              btn_enter;
    logic              btn_clear;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [SEL_W-1:0]  op_sel;
    logic              op_valid;
    logic              op_start;
    logic [1:0]        state_o;

    alu_operand_loader #(
        .DATA_W          (DATA_W),
        .SEL_W           (SEL_W),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sw_data   (sw_data),
        .sw_sel    (sw_sel),
        .btn_enter (btn_enter),
        .btn_clear (btn_clear),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .op_valid  (op_valid),
        .op_start  (op_start),
        .state_o   (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic              en;
        logic              cl;
        logic [DATA_W-1:0] d;
        logic [SEL_W-1:0]  s;
        logic [1:0]        st;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [SEL_W-1:0]  sel;
        logic              valid;
        logic              start;
    } vec_t;

    localparam int NVEC = 10;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic en, input logic cl,
                                input logic [DATA_W-1:0] d, input logic [SEL_W-1:0] s,
                                input logic [1:0] st, input logic [DATA_W-1:0] a,
                                input logic [DATA_W-1:0] b, input logic [SEL_W-1:0] sel,
                                input logic valid, input logic start);
        vec_t v;
        v.en = en; v.cl = cl; v.d = d; v.s = s; v.st = st;
        v.a = a; v.b = b; v.sel = sel; v.valid = valid; v.start = start;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] st, input logic [DATA_W-1:0] a,
                           input logic [DATA_W-1:0] b, input logic [SEL_W-1:0] sel,
                           input logic valid, input logic start);
        chk({tag, ".state"}, 32'(state_o), 32'(st));
        chk({tag, ".op_a"}, 32'(op_a), 32'(a));
        chk({tag, ".op_b"}, 32'(op_b), 32'(b));
        chk({tag, ".op_sel"}, 32'(op_sel), 32'(sel));
        chk({tag, ".op_valid"}, 32'(op_valid), 32'(valid));
        chk({tag, ".op_start"}, 32'(op_start), 32'(start));
    endtask

    logic [1:0] prev_st;

    initial begin
        // Row: enter, clear, sw_data, sw_sel -> state, a, b, sel, valid, start
        vecs[0] = mk(1, 0, 4'h5, 3'd0, 2'b01, 4'h5, 4'h0, 3'd0, 0, 0);
        vecs[1] = mk(1, 0, 4'hB, 3'd0, 2'b10, 4'h5, 4'hB, 3'd0, 0, 0);
        vecs[2] = mk(1, 0, 4'h0, 3'd1, 2'b11, 4'h5, 4'hB, 3'd1, 1, 1);
        vecs[3] = mk(1, 0, 4'h2, 3'd4, 2'b01, 4'h2, 4'hB, 3'd1, 0, 0);
        vecs[4] = mk(1, 0, 4'h7, 3'd0, 2'b10, 4'h2, 4'h7, 3'd1, 0, 0);
        vecs[5] = mk(1, 0, 4'h3, 3'd6, 2'b11, 4'h2, 4'h7, 3'd6, 1, 1);
        vecs[6] = mk(0, 1, 4'h9, 3'd5, 2'b00, 4'h0, 4'h0, 3'd0, 0, 0);
        vecs[7] = mk(1, 0, 4'hF, 3'd0, 2'b01, 4'hF, 4'h0, 3'd0, 0, 0);
        vecs[8] = mk(1, 0, 4'hE, 3'd0, 2'b10, 4'hF, 4'hE, 3'd0, 0, 0);
        vecs[9] = mk(1, 1, 4'hA, 3'd7, 2'b00, 4'h0, 4'h0, 3'd0, 0, 0);

        rst_n     = 1'b0;
        sw_data   = 4'h6;
        sw_sel    = 3'd3;
        btn_enter = 1'b0;
        btn_clear = 1'b0;

        // Reset held while buttons toggle
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn_enter = i[0];
            btn_clear = ~i[0];
        end
        @(posedge clk); #1;
        chk_all("reset", 2'b00, 4'h0, 4'h0, 3'd0, 0, 0);

        @(negedge clk);
        btn_enter = 1'b0;
        btn_clear = 1'b0;
        rst_n     = 1'b1;
        repeat (100) @(negedge clk);
        chk_all("idle", 2'b00, 4'h0, 4'h0, 3'd0, 0, 0);

        // Table of clean presses
        prev_st = 2'b00;
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            sw_data   = vecs[v].d;
            sw_sel    = vecs[v].s;
            btn_enter = vecs[v].en;
            btn_clear = vecs[v].cl;
            repeat (CAP_EDGE - 1) @(posedge clk);
            #1 chk($sformatf("vec%0d.pre_state", v), 32'(state_o), 32'(prev_st));
            @(posedge clk); #1;
            chk_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].a, vecs[v].b,
                    vecs[v].sel, vecs[v].valid, vecs[v].start);
            @(posedge clk); #1;
            chk($sformatf("vec%0d.start_pulse", v), 32'(op_start), 32'(0));
            @(negedge clk);
            btn_enter = 1'b0;
            btn_clear = 1'b0;
            sw_data   = ~vecs[v].d;
            sw_sel    = ~vecs[v].s;
            repeat (12) @(negedge clk);
            chk_all($sformatf("vec%0d.hold", v), vecs[v].st, vecs[v].a, vecs[v].b,
                    vecs[v].sel, vecs[v].valid, 0);
            prev_st = vecs[v].st;
        end

        // Bouncing enter then steady high: one capture after the final rise
        @(negedge clk);
        sw_data = 4'hC;
        for (int i = 0; i < 10; i++) begin
            btn_enter = (i % 2 == 0);
            @(negedge clk);
        end
        btn_enter = 1'b1;
        repeat (CAP_EDGE - 1) @(posedge clk);
        #1 chk("bounce.pre_state", 32'(state_o), 32'(2'b00));
        @(posedge clk); #1;
        chk_all("bounce", 2'b01, 4'hC, 4'h0, 3'd0, 0, 0);
        repeat (20) @(negedge clk);
        chk("bounce.single", 32'(state_o), 32'(2'b01));
        btn_enter = 1'b0;
        repeat (12) @(negedge clk);

        // Three-cycle glitch is filtered
        sw_data   = 4'h1;
        btn_enter = 1'b1;
        repeat (3) @(negedge clk);
        btn_enter = 1'b0;
        repeat (20) @(negedge clk);
        chk_all("glitch", 2'b01, 4'hC, 4'h0, 3'd0, 0, 0);

        // Async reset during a counting press; held button re-debounces once
        sw_data   = 4'h9;
        btn_enter = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_all("async_rst", 2'b00, 4'h0, 4'h0, 3'd0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (CAP_EDGE - 1) @(posedge clk);
        #1 chk("rst_press.pre_state", 32'(state_o), 32'(2'b00));
        @(posedge clk); #1;
        chk_all("rst_press", 2'b01, 4'h9, 4'h0, 3'd0, 0, 0);
        repeat (20) @(negedge clk);
        chk_all("rst_press.single", 2'b01, 4'h9, 4'h0, 3'd0, 0, 0);
        btn_enter = 1'b0;
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
